// File: rtl/clock_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_sel_ctrl
//  Description : Request-driven select controller for a three-source
//                glitch-free clock switch, with settle/dwell timing and a
//                completed-switch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_sel_ctrl #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned DWELL_CYC  = 16,
    parameter logic [1:0]  RST_SEL    = 2'b00,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_sel,
    output logic             req_ready,
    output logic [1:0]       clk_sel,
    output logic             busy,
    output logic             sw_done,
    output logic             req_err,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int unsigned c_MAX_CYC = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int unsigned c_TMR_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_TMR_W-1:0] c_SETTLE_LOAD = c_TMR_W'(SETTLE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_DWELL_LOAD  = c_TMR_W'(DWELL_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ZERO    = '0;
    localparam logic [1:0]         c_SEL_ILLEGAL = 2'b11;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    logic [1:0]         r_state;
    logic [c_TMR_W-1:0] r_cnt;
    logic [1:0]         r_clk_sel;
    logic               r_sw_done;
    logic               r_req_err;
    logic [CNT_W-1:0]   r_switch_cnt;
    logic               w_idle;

    assign w_idle = (r_state == c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= c_TMR_ZERO;
            r_clk_sel    <= RST_SEL;
            r_sw_done    <= 1'b0;
            r_req_err    <= 1'b0;
            r_switch_cnt <= '0;
        end else begin
            r_sw_done <= 1'b0;
            r_req_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Illegal and same-source requests are acknowledged without leaving IDLE
                    if (req_valid) begin
                        if (req_sel == c_SEL_ILLEGAL) begin
                            r_req_err <= 1'b1;
                        end else if (req_sel != r_clk_sel) begin
                            r_clk_sel <= req_sel;
                            r_state   <= c_ST_SETTLE;
                            r_cnt     <= c_SETTLE_LOAD;
                        end
                    end
                end
                c_ST_SETTLE: begin
                    if (r_cnt != c_TMR_ZERO) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state      <= c_ST_HOLD;
                        r_cnt        <= c_DWELL_LOAD;
                        r_sw_done    <= 1'b1;
                        r_switch_cnt <= r_switch_cnt + 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt != c_TMR_ZERO) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= c_TMR_ZERO;
                end
            endcase
        end
    end

    assign req_ready  = w_idle;
    assign busy       = ~w_idle;
    assign clk_sel    = r_clk_sel;
    assign sw_done    = r_sw_done;
    assign req_err    = r_req_err;
    assign switch_cnt = r_switch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clock_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_sel_ctrl
//  Description : Directed self-checking bench for clock_sel_ctrl (default
//                timing instance plus a narrow-counter wrap instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_sel_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [1:0] clk_sel;
    logic       busy;
    logic       sw_done;
    logic       req_err;
    logic [7:0] switch_cnt;

    logic       req_valid_b;
    logic [1:0] req_sel_b;
    logic       req_ready_b;
    logic [1:0] clk_sel_b;
    logic       busy_b;
    logic       sw_done_b;
    logic       req_err_b;
    logic [1:0] switch_cnt_b;

    int checks = 0;
    int errors = 0;

    clock_sel_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .clk_sel    (clk_sel),
        .busy       (busy),
        .sw_done    (sw_done),
        .req_err    (req_err),
        .switch_cnt (switch_cnt)
    );

    clock_sel_ctrl #(
        .SETTLE_CYC (2),
        .DWELL_CYC  (1),
        .RST_SEL    (2'b01),
        .CNT_W      (2)
    ) u_dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_sel    (req_sel_b),
        .req_ready  (req_ready_b),
        .clk_sel    (clk_sel_b),
        .busy       (busy_b),
        .sw_done    (sw_done_b),
        .req_err    (req_err_b),
        .switch_cnt (switch_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full switch on the default instance: 8 settle + 16 dwell cycles
    task automatic do_switch(input logic [1:0] sel, input logic [7:0] exp_cnt);
        int   busy_n;
        int   done_at;
        int   done_n;
        logic sel_ok;
        req_valid = 1'b1;
        req_sel   = sel;
        tick();
        req_valid = 1'b0;
        req_sel   = 2'b00;
        chk("accept_clk_sel", {30'd0, clk_sel}, {30'd0, sel});
        busy_n  = 0;
        done_at = -1;
        done_n  = 0;
        sel_ok  = 1'b1;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_n++;
            if (clk_sel !== sel) sel_ok = 1'b0;
            tick();
            if (sw_done === 1'b1) begin
                done_n++;
                done_at = i + 1;
            end
        end
        chk("busy_cycles", busy_n, 24);
        chk("sw_done_edge", done_at, 8);
        chk("sw_done_once", done_n, 1);
        chk("sel_stable", {31'd0, sel_ok}, 1);
        chk("ready_after", {31'd0, req_ready}, 1);
        chk("switch_cnt", {24'd0, switch_cnt}, {24'd0, exp_cnt});
    endtask

    task automatic do_switch_b(input logic [1:0] sel, input logic [1:0] exp_cnt);
        int busy_n;
        req_valid_b = 1'b1;
        req_sel_b   = sel;
        tick();
        req_valid_b = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20 && busy_b; i++) begin
            busy_n++;
            tick();
        end
        chk("wrap_busy_cycles", busy_n, 3);
        chk("wrap_clk_sel", {30'd0, clk_sel_b}, {30'd0, sel});
        chk("wrap_switch_cnt", {30'd0, switch_cnt_b}, {30'd0, exp_cnt});
    endtask

    initial begin
        #1_000_000;
        $fatal(1, "FAIL global_timeout: observed=running expected=finished");
    end

    initial begin
        int n;
        int bc;
        int dn;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_sel     = 2'b00;
        req_valid_b = 1'b0;
        req_sel_b   = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        // Reset defaults
        chk("rst_clk_sel", {30'd0, clk_sel}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sw_done", {31'd0, sw_done}, 0);
        chk("rst_req_err", {31'd0, req_err}, 0);
        chk("rst_switch_cnt", {24'd0, switch_cnt}, 0);
        chk("rst_b_clk_sel", {30'd0, clk_sel_b}, 32'd1);
        chk("rst_b_switch_cnt", {30'd0, switch_cnt_b}, 0);

        // Single switch 00 -> 01
        do_switch(2'b01, 8'd1);

        // Illegal then no-op on consecutive edges
        req_valid = 1'b1;
        req_sel   = 2'b11;
        tick();
        chk("illegal_req_err", {31'd0, req_err}, 1);
        chk("illegal_clk_sel", {30'd0, clk_sel}, 32'd1);
        chk("illegal_busy", {31'd0, busy}, 0);
        chk("illegal_ready", {31'd0, req_ready}, 1);
        req_sel = 2'b01;
        tick();
        chk("noop_req_err_clear", {31'd0, req_err}, 0);
        chk("noop_busy", {31'd0, busy}, 0);
        req_valid = 1'b0;
        tick();
        chk("noop_sw_done", {31'd0, sw_done}, 0);
        chk("noop_busy_later", {31'd0, busy}, 0);
        chk("noop_switch_cnt", {24'd0, switch_cnt}, 1);
        chk("noop_clk_sel", {30'd0, clk_sel}, 32'd1);

        do_switch(2'b10, 8'd2);
        do_switch(2'b00, 8'd3);

        // 00 -> 10, then 01 held across the busy window
        req_valid = 1'b1;
        req_sel   = 2'b10;
        tick();
        chk("held_first_sel", {30'd0, clk_sel}, 32'd2);
        req_sel = 2'b01;
        n  = 0;
        bc = 0;
        for (int i = 0; i < 100 && clk_sel === 2'b10; i++) begin
            if (busy) bc++;
            tick();
            n++;
        end
        req_valid = 1'b0;
        chk("held_accept_edge", n, 25);
        chk("held_busy_cycles", bc, 24);
        chk("held_second_sel", {30'd0, clk_sel}, 32'd1);
        chk("held_cnt_mid", {24'd0, switch_cnt}, 4);
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("held_cnt_done", {24'd0, switch_cnt}, 5);
        chk("held_ready", {31'd0, req_ready}, 1);
        do_switch(2'b00, 8'd6);

        // Reset three cycles into SETTLE, with a request present during reset
        req_valid = 1'b1;
        req_sel   = 2'b10;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_sel   = 2'b01;
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        chk("midrst_clk_sel", {30'd0, clk_sel}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_ready", {31'd0, req_ready}, 1);
        chk("midrst_switch_cnt", {24'd0, switch_cnt}, 0);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sw_done !== 1'b0 || busy !== 1'b0) dn++;
        end
        chk("midrst_no_activity", dn, 0);

        // Narrow counter wraps after four switches
        do_switch_b(2'b00, 2'd1);
        do_switch_b(2'b01, 2'd2);
        do_switch_b(2'b10, 2'd3);
        do_switch_b(2'b01, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_sel_ctrl.md
# clock_sel_ctrl

Request-driven controller that produces the 2-bit `clk_sel` consumed by the downstream three-source glitch-free clock switch (800/500/1000 MHz). Software or a power manager issues switch requests over a valid/ready handshake. The block does three things:
- rejects illegal codes;
- holds `clk_sel` stable for a settle window, so the switch's internal handover completes, followed by a minimum dwell window;
- counts completed switches.

It runs on a single always-on control clock, not on any of the switched clocks.

## Interface
- `SETTLE_CYC`, default 8: cycles `clk_sel` is held after a change before the switch is considered complete. Must be ≥1.
- `DWELL_CYC`, default 16: further cycles after settle before a new request is accepted. Must be ≥1.
- `RST_SEL`, default 2'b00: `clk_sel` value in and after reset. Must be a legal code.
- `CNT_W`, default 8: width of `switch_cnt`.

Ports:
- `clk`  in  1  always-on control clock. One clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_sel`  in  2  requested source: 00 = 800M, 01 = 500M, 10 = 1000M, 11 = illegal.
- `req_ready`  out  1  block can accept a request.
- `clk_sel`  out  2  registered select to the clock switch.
- `busy`  out  1  switch in progress (SETTLE or HOLD).
- `sw_done`  out  1  one-cycle pulse when settle completes.
- `req_err`  out  1  one-cycle pulse for an illegal request.
- `switch_cnt`  out  CNT_W  number of completed switches, wraps modulo 2^CNT_W.

## Operation
- FSM states are IDLE, SETTLE and HOLD. A down-counter `cnt` is wide enough for max(SETTLE_CYC, DWELL_CYC)−1.
- `req_ready` = (state == IDLE). `busy` = (state != IDLE).
- A request is accepted on a rising edge where `req_valid` and `req_ready` are both high. `req_sel` is sampled only at acceptance.
- IDLE, accept, `req_sel` == 11:
  - `req_err` = 1 for the next cycle.
  - `clk_sel` is unchanged and the state stays IDLE.
- IDLE, accept, `req_sel` == `clk_sel`:
  - Acknowledged as a no-op.
  - No state change, no `sw_done`, no count.
- IDLE, accept, legal `req_sel` different from `clk_sel`:
  - `clk_sel` <= `req_sel`.
  - State <= SETTLE, `cnt` <= SETTLE_CYC−1.
- SETTLE:
  - `cnt` != 0: decrement.
  - `cnt` == 0: state <= HOLD, `cnt` <= DWELL_CYC−1, `sw_done` <= 1 for one cycle, `switch_cnt` <= `switch_cnt` + 1 (wraps).
- HOLD:
  - `cnt` != 0: decrement.
  - `cnt` == 0: state <= IDLE.
- `req_valid` while busy is ignored. The requester holds the request until `req_ready` is high; no request is queued.
- `clk_sel` changes only on the accept edge and never during SETTLE or HOLD.

## Timing
- Reset values: state IDLE, `clk_sel` = RST_SEL, `busy` 0, `sw_done` 0, `req_err` 0, `switch_cnt` 0, `cnt` 0.
- Reset has priority over everything. A request in a cycle with `rst` high is not accepted.
- `req_ready` is 1 from the first cycle after `rst` deasserts.
- Reset mid-SETTLE or mid-HOLD: on the next edge, `clk_sel` returns to RST_SEL, the state goes to IDLE and `switch_cnt` clears. No `sw_done` is issued.
- Switch latency, with accept at edge T:
  - `clk_sel` is new after T.
  - `sw_done` is high in the cycle after edge T+SETTLE_CYC.
  - `req_ready` returns high after edge T+SETTLE_CYC+DWELL_CYC.
  - `busy` is high for exactly SETTLE_CYC+DWELL_CYC cycles.
- Back-to-back: a request held high across busy is accepted on the first edge with `req_ready` = 1. Minimum accept-to-accept spacing is SETTLE_CYC+DWELL_CYC+1 edges.
- `req_err` and no-op accepts leave `req_ready` high, so consecutive accepts on consecutive edges are allowed.
- `switch_cnt` wraps from 2^CNT_W−1 to 0.

## Test plan
- Reset then idle, defaults: after reset, `clk_sel` = 00, `req_ready` = 1, `busy` = 0, `switch_cnt` = 0.
- Single switch: request 01 held for one cycle.
  - `clk_sel` = 01 the next cycle.
  - `sw_done` pulses 8 edges later, `switch_cnt` = 1.
  - `busy` is high for 24 cycles, then `req_ready` = 1.
- Illegal and no-op requests:
  - `req_sel` = 11 → `req_err` pulses for one cycle, `clk_sel` unchanged, `busy` = 0.
  - `req_sel` equal to the current select → no `busy`, no `sw_done`, count unchanged.
- Held request during busy: sequence 00→10, then 01 asserted immediately and held.
  - 01 is accepted exactly on the edge where `req_ready` rises.
  - `clk_sel` is stable at 10 for all 24 busy cycles.
  - The sequence 00→01→10→00→10→01→00 ends with `switch_cnt` = 6.
- Reset mid-SETTLE: assert `rst` 3 cycles after a 00→10 accept.
  - `clk_sel` returns to 00, state IDLE, `switch_cnt` = 0.
  - No `sw_done` is issued.
- Wrap: with CNT_W = 2, four completed switches → `switch_cnt` reads 0.
